// File: rtl/sram_ctrl_if.sv
// Host-side request/response bus of the SRAM controller.
// The host drives requests; the controller answers with ready, a completion pulse and read data.
interface sram_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_word;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic [15:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// Host-side controller for a 128K x 8 asynchronous SRAM; a word access runs as two byte
// cycles, low byte first. All SRAM pins come straight from flops so the strobes never glitch.
//
// state   | meaning
// IDLE    | CE inactive, ready for a request
// SETUP   | CE active, address and write data presented, strobes high
// STROBE  | WE# or OE# low for WAIT cycles
// RECOVER | strobes high for TURN cycles, CE/address/data held
// DONE    | one-cycle completion pulse, CE inactive
module sram_ctrl #(
    parameter int ADDR_W = 17,
    parameter int WAIT   = 3,
    parameter int TURN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_ce2,
    output logic              sram_we_n,
    output logic              sram_oe_n
);
    localparam int CNT_MAX = (WAIT > TURN) ? WAIT : TURN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              idx_q, idx_d;
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [7:0]        dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              ce2_q, ce2_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        a_d     = a_q;
        dq_o_d  = dq_o_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d    = bus.req_we;
                    word_d  = bus.req_word;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    idx_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(WAIT - 1);
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_W'(TURN - 1);
                    // Low byte clears the upper half so a byte read returns {00, byte}.
                    if (!we_q)
                        rdata_d = idx_q ? {sram_dq_i, rdata_q[7:0]} : {8'h00, sram_dq_i};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    if (word_q && !idx_q) begin
                        idx_d   = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Address and write data move only when a byte cycle starts.
        if (state_d == SETUP) begin
            a_d = addr_d + ADDR_W'(idx_d);
            if (we_d)
                dq_o_d = idx_d ? wdata_d[15:8] : wdata_d[7:0];
        end

        active       = (state_d == SETUP) || (state_d == STROBE) || (state_d == RECOVER);
        ce_n_d       = !active;
        ce2_d        = active;
        dq_oe_d      = active && we_d;
        we_n_d       = !((state_d == STROBE) && we_d);
        oe_n_d       = !((state_d == STROBE) && !we_d);
        resp_valid_d = (state_d == DONE);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 1'b0;
            we_q         <= 1'b0;
            word_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            a_q          <= '0;
            dq_o_q       <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            ce2_q        <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            a_q          <= a_d;
            dq_o_q       <= dq_o_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            ce2_q        <= ce2_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign sram_a         = a_q;
    assign sram_dq_o      = dq_o_q;
    assign sram_dq_oe     = dq_oe_q;
    assign sram_ce_n      = ce_n_q;
    assign sram_ce2       = ce2_q;
    assign sram_we_n      = we_n_q;
    assign sram_oe_n      = oe_n_q;
endmodule
